// File: rtl/rob_alloc_ctrl.sv
// ROB tag allocator: same-cycle combinational grants/tags, pointer updates next cycle; grants a prefix only when free slots allow.
// Optional stats counters are enabled by defining ROB_ALLOC_STATS_EN.
module rob_alloc_ctrl #(
  parameter int PIPE_WIDTH = 2,
  parameter int ROB_DEPTH  = 32,
  parameter int TAG_WIDTH  = $clog2(ROB_DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [PIPE_WIDTH-1:0]           alloc_req,
  input  logic                            alloc_take,
  output logic [PIPE_WIDTH-1:0]           alloc_gnt,
  output logic [PIPE_WIDTH*TAG_WIDTH-1:0] alloc_tags,
  input  logic [PIPE_WIDTH-1:0]           commit_valid,
  output logic [TAG_WIDTH-1:0]            head_tag,
  output logic [TAG_WIDTH:0]              rob_count,
  output logic                            rob_full,
  output logic                            rob_empty
`ifdef ROB_ALLOC_STATS_EN
  ,
  output logic [31:0]                     stat_alloc_cnt,
  output logic [31:0]                     stat_full_stall_cnt
`endif
);

  localparam logic [TAG_WIDTH:0] DEPTH_C = (TAG_WIDTH+1)'(ROB_DEPTH);
  localparam logic [TAG_WIDTH:0] ONE_C   = (TAG_WIDTH+1)'(1);
  localparam logic [TAG_WIDTH:0] TWO_C   = (TAG_WIDTH+1)'(2);

  typedef enum logic {RUN, RECOVER} state_t;

  state_t               state;
  logic [TAG_WIDTH-1:0] head, tail, head_next, tail_next, tag0, tag1;
  logic [TAG_WIDTH:0]   count, count_next, free, need1, sum, commit_ext;
  logic [1:0]           gnt_raw, n_alloc, n_commit;

  assign free  = DEPTH_C - count;
  assign need1 = alloc_req[0] ? TWO_C : ONE_C;

  always_comb begin
    gnt_raw = '0;
    if (state == RUN) begin
      gnt_raw[0] = alloc_req[0] && (free >= ONE_C);
      gnt_raw[1] = alloc_req[1] && (free >= need1);
    end
  end

  // A lone lane-1 request gets the tail tag itself.
  assign tag0 = tail;
  assign tag1 = tail + TAG_WIDTH'(alloc_req[0]);

  assign alloc_gnt  = rst ? '0 : gnt_raw;
  assign alloc_tags = rst ? '0 : {tag1, tag0};
  assign head_tag   = head;
  assign rob_count  = count;
  assign rob_full   = (count == DEPTH_C);
  assign rob_empty  = (count == '0);

  assign n_alloc    = (alloc_take && !flush) ? (2'(gnt_raw[0]) + 2'(gnt_raw[1])) : 2'd0;
  assign n_commit   = 2'(commit_valid[0]) + 2'(commit_valid[1]);
  assign commit_ext = (TAG_WIDTH+1)'(n_commit);
  assign head_next  = head + TAG_WIDTH'(n_commit);
  assign tail_next  = tail + TAG_WIDTH'(n_alloc);
  assign sum        = count + (TAG_WIDTH+1)'(n_alloc);
  // Saturate so an illegal over-commit cannot wrap the count.
  assign count_next = (sum < commit_ext) ? '0 : (sum - commit_ext);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= RUN;
    end else begin
      head <= head_next;
      if (flush) begin
        tail  <= head_next;
        count <= '0;
        state <= RECOVER;
      end else begin
        tail  <= tail_next;
        count <= count_next;
        state <= RUN;
      end
    end
  end

`ifdef ROB_ALLOC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_alloc_cnt      <= '0;
      stat_full_stall_cnt <= '0;
    end else begin
      stat_alloc_cnt <= stat_alloc_cnt + 32'(n_alloc);
      if (state == RUN && (|alloc_req) && (gnt_raw != alloc_req))
        stat_full_stall_cnt <= stat_full_stall_cnt + 32'd1;
    end
  end
`endif

  a_no_over_commit: assert property (@(posedge clk) disable iff (rst) commit_ext <= count);

endmodule
